ppm_mmio_bridge: RTL

CPU-facing MMIO front end for the PPM framebuffer sink. Decodes word-aligned bus reads and writes into a small register map and keeps the pixel cursor, filename index and a hardware frame-fill engine. Converts accepted writes into sink commands queued in a FIFO. Drains the FIFO in order onto the sink's valid/ready port (`input_valid`/`input_ready`, `address`, `data`, `operation`, `dump`), so dumps are issued only after every earlier write.

---
 rtl/ppm_mmio_pkg.sv | 35 +++
 rtl/ppm_cmd_fifo.sv | 49 ++++
 rtl/ppm_mmio_bridge.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ppm_mmio_pkg.sv
// Shared constants and command payload for the PPM MMIO bridge.
package ppm_mmio_pkg;

    localparam logic [1:0] PPM_OP_PIXEL = 2'd1;
    localparam logic [1:0] PPM_OP_FNAME = 2'd2;
    localparam logic [1:0] OP_DUMP      = 2'd3;

    localparam logic [7:0] REG_CURSOR = 8'h00;
    localparam logic [7:0] REG_PIXEL  = 8'h04;
    localparam logic [7:0] REG_FNAME  = 8'h08;
    localparam logic [7:0] REG_CTRL   = 8'h0C;
    localparam logic [7:0] REG_STATUS = 8'h10;
    localparam logic [7:0] REG_COLOR  = 8'h14;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DUMPQ = 2'd2;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [23:0] data;
    } ppm_cmd_t;

    localparam int unsigned CMD_W = $bits(ppm_cmd_t);

    function automatic ppm_cmd_t make_cmd(logic [1:0] op, logic [15:0] addr, logic [23:0] data);
        ppm_cmd_t c;
        c.op   = op;
        c.addr = addr;
        c.data = data;
        return c;
    endfunction

endpackage

// File: rtl/ppm_cmd_fifo.sv
// Synchronous command FIFO; head is read straight from storage, so a push shows one cycle later.
module ppm_cmd_fifo
    import ppm_mmio_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [CMD_W-1:0]         wr_cmd,
    input  logic                     pop,
    output logic [CMD_W-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_cmd;
    end

endmodule

// File: rtl/ppm_mmio_bridge.sv
// CPU MMIO front end for the PPM sink: register decode, cursor/filename counters,
// frame-fill engine and in-order drain of queued sink commands.
module ppm_mmio_bridge
    import ppm_mmio_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH  = 100,
    parameter int unsigned FRAME_HEIGHT = 100,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bus_req_valid,
    output logic        bus_req_ready,
    input  logic        bus_req_we,
    input  logic [7:0]  bus_req_addr,
    input  logic [31:0] bus_req_wdata,
    output logic        bus_resp_valid,
    output logic [31:0] bus_resp_rdata,
    output logic        ppm_valid,
    input  logic        ppm_ready,
    output logic [31:0] ppm_address,
    output logic [31:0] ppm_data,
    output logic [31:0] ppm_operation,
    output logic        ppm_dump
);

    localparam int unsigned NPIX     = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] LAST_PIX = 16'(NPIX - 1);

    logic [1:0]       state, state_nx;
    logic [15:0]      fill_idx, fill_idx_nx;
    logic             dump_pend, dump_pend_nx;
    logic [15:0]      cursor;
    logic [7:0]       fidx;
    logic [23:0]      color;
    logic             err;
    logic             resp_valid_q;
    logic [31:0]      resp_rdata_q;
    logic [31:0]      rd_data;
    logic [7:0]       reg_off;
    logic             acc, wr, rd;
    logic             push, pop, full, empty, head_is_dump;
    ppm_cmd_t         push_cmd, head;
    logic [CMD_W-1:0] head_bits;
    logic [CW-1:0]    count;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^bus_req_addr[1:0];

    assign reg_off       = {bus_req_addr[7:2], 2'b00};
    assign bus_req_ready = reset && (state == ST_IDLE) && !full;
    assign acc           = bus_req_valid && bus_req_ready;
    assign wr            = acc && bus_req_we;
    assign rd            = acc && !bus_req_we;

    ppm_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .push   (push),
        .wr_cmd (push_cmd),
        .pop    (pop),
        .head   (head_bits),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            fill_idx  <= '0;
            dump_pend <= 1'b0;
        end else begin
            state     <= state_nx;
            fill_idx  <= fill_idx_nx;
            dump_pend <= dump_pend_nx;
        end
    end

    // Command sources are exclusive: bus writes only land in IDLE, the fill engine owns FILL/DUMPQ.
    always_comb begin
        state_nx     = state;
        fill_idx_nx  = fill_idx;
        dump_pend_nx = dump_pend;
        push         = 1'b0;
        push_cmd     = '0;
        case (state)
            ST_IDLE: begin
                if (wr) begin
                    case (reg_off)
                        REG_PIXEL: begin
                            push     = 1'b1;
                            push_cmd = make_cmd(PPM_OP_PIXEL, cursor, bus_req_wdata[23:0]);
                        end
                        REG_FNAME: begin
                            push     = 1'b1;
                            push_cmd = make_cmd(PPM_OP_FNAME, 16'(fidx), 24'(bus_req_wdata[7:0]));
                        end
                        REG_CTRL: begin
                            if (bus_req_wdata[2]) begin
                                state_nx     = ST_FILL;
                                fill_idx_nx  = '0;
                                dump_pend_nx = bus_req_wdata[0];
                            end else if (bus_req_wdata[0]) begin
                                push     = 1'b1;
                                push_cmd = make_cmd(OP_DUMP, 16'd0, 24'd0);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_FILL: begin
                if (!full) begin
                    push     = 1'b1;
                    push_cmd = make_cmd(PPM_OP_PIXEL, fill_idx, color);
                    if (fill_idx == LAST_PIX) begin
                        state_nx    = dump_pend ? ST_DUMPQ : ST_IDLE;
                        fill_idx_nx = '0;
                    end else begin
                        fill_idx_nx = fill_idx + 16'd1;
                    end
                end
            end
            ST_DUMPQ: begin
                if (!full) begin
                    push         = 1'b1;
                    push_cmd     = make_cmd(OP_DUMP, 16'd0, 24'd0);
                    state_nx     = ST_IDLE;
                    dump_pend_nx = 1'b0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cursor <= '0;
            fidx   <= '0;
            color  <= '0;
            err    <= 1'b0;
        end else if (wr) begin
            case (reg_off)
                REG_CURSOR: begin
                    if (bus_req_wdata < 32'(NPIX)) cursor <= bus_req_wdata[15:0];
                    else                           err    <= 1'b1;
                end
                REG_PIXEL:  cursor <= (cursor == LAST_PIX) ? 16'd0 : cursor + 16'd1;
                REG_FNAME:  fidx   <= fidx + 8'd1;
                REG_CTRL:   if (bus_req_wdata[1]) fidx <= '0;
                REG_STATUS: if (bus_req_wdata[16]) err <= 1'b0;
                REG_COLOR:  color  <= bus_req_wdata[23:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_off)
            REG_CURSOR: rd_data = 32'(cursor);
            REG_STATUS: rd_data = {15'd0, err, 8'(count), 6'd0, full, empty};
            REG_COLOR:  rd_data = {8'd0, color};
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= acc;
            resp_rdata_q <= rd ? rd_data : 32'd0;
        end
    end

    assign bus_resp_valid = reset && resp_valid_q;
    assign bus_resp_rdata = reset ? resp_rdata_q : 32'd0;

    // A DUMP head never handshakes: it strobes ppm_dump and retires on its own.
    assign head          = ppm_cmd_t'(head_bits);
    assign head_is_dump  = !empty && (head.op == OP_DUMP);
    assign ppm_valid     = reset && !empty && !head_is_dump;
    assign ppm_dump      = reset && head_is_dump;
    assign pop           = head_is_dump || (ppm_valid && ppm_ready);
    assign ppm_address   = ppm_valid ? 32'(head.addr) : 32'd0;
    assign ppm_data      = ppm_valid ? 32'(head.data) : 32'd0;
    assign ppm_operation = ppm_valid ? 32'(head.op)   : 32'd0;

endmodule
